// File: rtl/cache_arb_pkg.sv
// Shared types and sizing helpers for the icache/dcache memory request arbiter.
package cache_arb_pkg;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam int unsigned DefMaxOutstanding = 2;
  localparam int unsigned CntWidth          = $clog2(DefMaxOutstanding + 1);

  // Counter width able to hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant pointer moves only on upd_i.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  src_e r_last;

  always_comb begin
    // NOTE: default assignment first so no path leaves gnt_o unassigned (no latch).
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (r_last == DC) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer starts at dcache so the first tie after reset goes to icache.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= DC;
    end else if (upd_i) begin
      r_last <= gnt_o[1] ? DC : IC;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges icache and dcache requests onto one memory port, tracks per-source
// outstanding transactions, routes responses back, and supports a drain handshake.
module mem_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     ic_req_valid_i,
  output logic                     ic_req_ready_o,
  input  logic [AddrWidth-1:0]     ic_req_addr_i,
  input  logic [TidWidth-2:0]      ic_req_tid_i,

  input  logic                     dc_req_valid_i,
  output logic                     dc_req_ready_o,
  input  logic [AddrWidth-1:0]     dc_req_addr_i,
  input  logic                     dc_req_we_i,
  input  logic [DataWidth-1:0]     dc_req_wdata_i,
  input  logic [DataWidth/8-1:0]   dc_req_be_i,
  input  logic [TidWidth-2:0]      dc_req_tid_i,

  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [AddrWidth-1:0]     mem_req_addr_o,
  output logic                     mem_req_we_o,
  output logic [DataWidth-1:0]     mem_req_wdata_o,
  output logic [DataWidth/8-1:0]   mem_req_be_o,
  output logic [TidWidth-1:0]      mem_req_tid_o,

  input  logic                     mem_rsp_valid_i,
  input  logic [TidWidth-1:0]      mem_rsp_tid_i,
  input  logic [DataWidth-1:0]     mem_rsp_data_i,

  output logic                     ic_rsp_valid_o,
  output logic                     dc_rsp_valid_o,
  output logic [TidWidth-2:0]      ic_rsp_tid_o,
  output logic [TidWidth-2:0]      dc_rsp_tid_o,
  output logic [DataWidth-1:0]     ic_rsp_data_o,
  output logic [DataWidth-1:0]     dc_rsp_data_o,

  input  logic                     drain_req_i,
  output logic                     drain_ack_o,
  output logic                     err_o
);

  localparam int unsigned     CntW   = cnt_width(MaxOutstanding);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  arb_state_e               r_state;
  logic                     r_drain_ack;
  logic                     r_err;
  logic [CntW-1:0]          r_cnt [2];

  logic                     r_mem_valid;
  logic [AddrWidth-1:0]     r_mem_addr;
  logic                     r_mem_we;
  logic [DataWidth-1:0]     r_mem_wdata;
  logic [DataWidth/8-1:0]   r_mem_be;
  logic [TidWidth-1:0]      r_mem_tid;

  logic                     r_ic_rsp_valid;
  logic                     r_dc_rsp_valid;
  logic [TidWidth-2:0]      r_rsp_tid;
  logic [DataWidth-1:0]     r_rsp_data;

  logic                     w_run_ok;
  logic                     w_can_load;
  logic                     w_accept;
  logic                     w_rsp_src;
  logic                     w_rsp_bad;
  logic                     w_idle;
  logic [1:0]               w_req;
  logic [1:0]               w_gnt;
  logic [1:0]               w_take;
  logic [1:0]               w_rsp_hit;

  // The drain request itself blocks accepts, so the RUN->DRAIN cycle takes nothing.
  always_comb begin
    w_run_ok     = (r_state == RUN) && !drain_req_i;
    w_req[0]     = ic_req_valid_i && w_run_ok && (r_cnt[0] < MaxCnt);
    w_req[1]     = dc_req_valid_i && w_run_ok && (r_cnt[1] < MaxCnt);
    w_rsp_src    = mem_rsp_tid_i[TidWidth-1];
    w_rsp_hit[0] = mem_rsp_valid_i && !w_rsp_src && (r_cnt[0] != '0);
    w_rsp_hit[1] = mem_rsp_valid_i &&  w_rsp_src && (r_cnt[1] != '0);
    w_rsp_bad    = mem_rsp_valid_i && (r_cnt[w_rsp_src] == '0);
    w_idle       = (r_cnt[0] == '0) && (r_cnt[1] == '0) && !r_mem_valid;
  end

  assign w_can_load = !r_mem_valid || mem_req_ready_i;

  rr_arb2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_req),
    .upd_i (w_accept),
    .gnt_o (w_gnt)
  );

  // Readies are held low during reset so every output is quiet while rst_i is high.
  assign w_take         = (w_can_load && !rst_i) ? w_gnt : 2'b00;
  assign w_accept       = |w_take;
  assign ic_req_ready_o = w_take[0];
  assign dc_req_ready_o = w_take[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < 2; s++) r_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        case ({w_take[s], w_rsp_hit[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CntOne;
          2'b01:   r_cnt[s] <= r_cnt[s] - CntOne;
          default: r_cnt[s] <= r_cnt[s];
        endcase
      end
    end
  end

  // NOTE: datapath registers are reset too, so the port reads all-zero right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_tid   <= '0;
    end else if (w_can_load) begin
      r_mem_valid <= w_accept;
      if (w_take[1]) begin
        r_mem_addr  <= dc_req_addr_i;
        r_mem_we    <= dc_req_we_i;
        r_mem_wdata <= dc_req_wdata_i;
        r_mem_be    <= dc_req_be_i;
        r_mem_tid   <= {1'b1, dc_req_tid_i};
      end else if (w_take[0]) begin
        r_mem_addr  <= ic_req_addr_i;
        r_mem_we    <= 1'b0;
        r_mem_wdata <= '0;
        r_mem_be    <= '0;
        r_mem_tid   <= {1'b0, ic_req_tid_i};
      end
    end
  end

  // One tid/data register serves both sources; the per-source valid says who owns it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ic_rsp_valid <= 1'b0;
      r_dc_rsp_valid <= 1'b0;
      r_rsp_tid      <= '0;
      r_rsp_data     <= '0;
    end else begin
      r_ic_rsp_valid <= w_rsp_hit[0];
      r_dc_rsp_valid <= w_rsp_hit[1];
      if (|w_rsp_hit) begin
        r_rsp_tid  <= mem_rsp_tid_i[TidWidth-2:0];
        r_rsp_data <= mem_rsp_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_drain_ack <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_rsp_bad) r_err <= 1'b1;
      case (r_state)
        RUN: begin
          if (drain_req_i) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_idle) begin
            r_state     <= DONE;
            r_drain_ack <= 1'b1;
          end
        end
        DONE: begin
          if (!drain_req_i) begin
            r_state     <= RUN;
            r_drain_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= RUN;
          r_drain_ack <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid_o = r_mem_valid;
  assign mem_req_addr_o  = r_mem_addr;
  assign mem_req_we_o    = r_mem_we;
  assign mem_req_wdata_o = r_mem_wdata;
  assign mem_req_be_o    = r_mem_be;
  assign mem_req_tid_o   = r_mem_tid;

  assign ic_rsp_valid_o  = r_ic_rsp_valid;
  assign dc_rsp_valid_o  = r_dc_rsp_valid;
  assign ic_rsp_tid_o    = r_rsp_tid;
  assign dc_rsp_tid_o    = r_rsp_tid;
  assign ic_rsp_data_o   = r_rsp_data;
  assign dc_rsp_data_o   = r_rsp_data;

  assign drain_ack_o     = r_drain_ack;
  assign err_o           = r_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scenarios plus a random run, each cycle compared against a
// transaction-level model of grants, outstanding counts, responses and drain.
module tb_mem_req_arbiter;

  localparam int AW = 64;
  localparam int DW = 128;
  localparam int TW = 2;
  localparam int BW = DW / 8;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_valid, ic_ready;
  logic [AW-1:0] ic_addr;
  logic [TW-2:0] ic_tid;
  logic          dc_valid, dc_ready, dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [BW-1:0] dc_be;
  logic [TW-2:0] dc_tid;
  logic          mem_valid, mem_ready, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [TW-1:0] mem_tid;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [DW-1:0] rsp_data;
  logic          ic_rsp_v, dc_rsp_v;
  logic [TW-2:0] ic_rsp_tid, dc_rsp_tid;
  logic [DW-1:0] ic_rsp_data, dc_rsp_data;
  logic          drain_req, drain_ack, err;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(ic_valid), .ic_req_ready_o(ic_ready),
    .ic_req_addr_i(ic_addr), .ic_req_tid_i(ic_tid),
    .dc_req_valid_i(dc_valid), .dc_req_ready_o(dc_ready),
    .dc_req_addr_i(dc_addr), .dc_req_we_i(dc_we), .dc_req_wdata_i(dc_wdata),
    .dc_req_be_i(dc_be), .dc_req_tid_i(dc_tid),
    .mem_req_valid_o(mem_valid), .mem_req_ready_i(mem_ready),
    .mem_req_addr_o(mem_addr), .mem_req_we_o(mem_we), .mem_req_wdata_o(mem_wdata),
    .mem_req_be_o(mem_be), .mem_req_tid_o(mem_tid),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_tid_i(rsp_tid), .mem_rsp_data_i(rsp_data),
    .ic_rsp_valid_o(ic_rsp_v), .dc_rsp_valid_o(dc_rsp_v),
    .ic_rsp_tid_o(ic_rsp_tid), .dc_rsp_tid_o(dc_rsp_tid),
    .ic_rsp_data_o(ic_rsp_data), .dc_rsp_data_o(dc_rsp_data),
    .drain_req_i(drain_req), .drain_ack_o(drain_ack), .err_o(err)
  );

  // Reference model state: transactions in flight per source, who won last,
  // what sits on the memory port, the last routed response, and the drain phase.
  int            m_cnt [2];
  int            m_last;
  bit            m_busy;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [TW-1:0] m_tid;
  bit            m_rv [2];
  logic [TW-2:0] m_rtid;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  int            m_phase;   // 0 running, 1 draining, 2 drained
  int            p_win;
  bit            p_room;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_last = 1;
    m_busy = 0;
    m_addr = '0; m_we = 0; m_wdata = '0; m_be = '0; m_tid = '0;
    m_rv[0] = 0; m_rv[1] = 0;
    m_err = 0;
    m_phase = 0;
  endtask

  task automatic idle();
    ic_valid = 0; ic_addr = '0; ic_tid = '0;
    dc_valid = 0; dc_addr = '0; dc_we = 0; dc_wdata = '0; dc_be = '0; dc_tid = '0;
    mem_ready = 0; rsp_valid = 0; rsp_tid = '0; rsp_data = '0;
    drain_req = 0;
  endtask

  task automatic predict();
    bit open_gate, ic_ok, dc_ok;
    open_gate = (m_phase == 0) && !drain_req;
    ic_ok = ic_valid && open_gate && (m_cnt[0] < MAXO);
    dc_ok = dc_valid && open_gate && (m_cnt[1] < MAXO);
    if (ic_ok && dc_ok) p_win = 1 - m_last;
    else if (ic_ok)     p_win = 0;
    else if (dc_ok)     p_win = 1;
    else                p_win = -1;
    p_room = !m_busy || mem_ready;
  endtask

  task automatic advance();
    bit was_empty;
    int s;
    was_empty = (m_cnt[0] == 0) && (m_cnt[1] == 0) && !m_busy;
    m_rv[0] = 0; m_rv[1] = 0;
    if (rsp_valid) begin
      s = int'(rsp_tid[TW-1]);
      if (m_cnt[s] == 0) m_err = 1;
      else begin
        m_rv[s] = 1;
        m_rtid  = rsp_tid[TW-2:0];
        m_rdata = rsp_data;
        m_cnt[s]--;
      end
    end
    if (p_room) begin
      m_busy = (p_win >= 0);
      if (p_win == 0) begin
        m_addr = ic_addr; m_we = 0; m_wdata = '0; m_be = '0; m_tid = {1'b0, ic_tid};
      end else if (p_win == 1) begin
        m_addr = dc_addr; m_we = dc_we; m_wdata = dc_wdata; m_be = dc_be; m_tid = {1'b1, dc_tid};
      end
      if (p_win >= 0) begin
        m_cnt[p_win]++;
        m_last = p_win;
      end
    end
    case (m_phase)
      0: if (drain_req) m_phase = 1;
      1: if (was_empty) m_phase = 2;
      default: if (!drain_req) m_phase = 0;
    endcase
  endtask

  // Inputs are set at edge+1; readies checked at edge+2; outputs at next edge+1.
  task automatic cycle();
    #1;
    predict();
    chk("ic_ready", ic_ready, (p_room && p_win == 0));
    chk("dc_ready", dc_ready, (p_room && p_win == 1));
    @(posedge clk);
    advance();
    #1;
    chk("mem_valid", mem_valid, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_be", mem_be, m_be);
      chk("mem_tid", mem_tid, m_tid);
    end
    chk("ic_rsp_v", ic_rsp_v, m_rv[0]);
    chk("dc_rsp_v", dc_rsp_v, m_rv[1]);
    if (m_rv[0]) begin
      chk("ic_rsp_tid", ic_rsp_tid, m_rtid);
      chk("ic_rsp_data", ic_rsp_data, m_rdata);
    end
    if (m_rv[1]) begin
      chk("dc_rsp_tid", dc_rsp_tid, m_rtid);
      chk("dc_rsp_data", dc_rsp_data, m_rdata);
    end
    chk("err", err, m_err);
    chk("drain_ack", drain_ack, (m_phase == 2));
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_tid", mem_tid, 0);
    chk("rst_ic_ready", ic_ready, 0);
    chk("rst_dc_ready", dc_ready, 0);
    chk("rst_ic_rsp_v", ic_rsp_v, 0);
    chk("rst_dc_rsp_v", dc_rsp_v, 0);
    chk("rst_err", err, 0);
    chk("rst_drain_ack", drain_ack, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    idle();
    do_reset();

    // Both sources valid from reset: tids alternate 00,10,00,10 then saturate.
    ic_valid = 1; ic_addr = 64'h1000; ic_tid = '0;
    dc_valid = 1; dc_addr = 64'h2000; dc_we = 0; dc_tid = '0;
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_tid", mem_tid, (k % 2 == 1) ? 2'b10 : 2'b00);
    end
    #1;
    chk("sat_ic_ready", ic_ready, 0);
    chk("sat_dc_ready", dc_ready, 0);
    cycle();

    // Dcache store stalled by mem_req_ready_i=0 for 5 cycles.
    idle();
    do_reset();
    dc_valid = 1; dc_we = 1; dc_addr = 64'h8000_0040; dc_be = '1; dc_tid = 1'b1;
    dc_wdata = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    ic_valid = 1; ic_addr = 64'h4000;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("st_addr", mem_addr, 64'h8000_0040);
      chk("st_be", mem_be, {BW{1'b1}});
      chk("st_we", mem_we, 1);
      chk("st_tid", mem_tid, 2'b11);
    end
    idle();
    mem_ready = 1;
    cycle();

    // Two dcache loads fill the budget; a tid 2'b11 response frees one slot.
    idle();
    do_reset();
    mem_ready = 1;
    dc_valid = 1; dc_addr = 64'h3000; dc_tid = 1'b0;
    cycle();
    dc_tid = 1'b1;
    cycle();
    cycle();
    #1;
    chk("dc_full_ready", dc_ready, 0);
    rsp_valid = 1; rsp_tid = 2'b11; rsp_data = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    rsp_valid = 0;
    chk("dc_rsp_valid", dc_rsp_v, 1);
    chk("dc_rsp_tid1", dc_rsp_tid, 1);
    chk("ic_rsp_quiet", ic_rsp_v, 0);
    #1;
    chk("dc_ready_back", dc_ready, 1);
    cycle();

    // Response for icache while it has nothing outstanding.
    idle();
    do_reset();
    rsp_valid = 1; rsp_tid = 2'b01; rsp_data = '1;
    cycle();
    rsp_valid = 0;
    chk("bad_ic_rsp_v", ic_rsp_v, 0);
    chk("bad_err", err, 1);
    repeat (3) cycle();
    chk("err_sticky", err, 1);

    // Drain with one transaction outstanding per source.
    idle();
    do_reset();
    mem_ready = 1;
    ic_valid = 1; ic_addr = 64'h5000;
    dc_valid = 1; dc_addr = 64'h6000;
    cycle();
    cycle();
    drain_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_no_ic", ic_ready, 0);
      chk("drain_no_dc", dc_ready, 0);
      cycle();
    end
    rsp_valid = 1; rsp_tid = 2'b00;
    cycle();
    rsp_valid = 0;
    cycle();
    chk("ack_wait", drain_ack, 0);
    rsp_valid = 1; rsp_tid = 2'b10;
    cycle();
    rsp_valid = 0;
    chk("ack_not_yet", drain_ack, 0);
    cycle();
    chk("ack_rise", drain_ack, 1);
    drain_req = 0;
    cycle();
    chk("ack_fall", drain_ack, 0);
    cycle();
    chk("resume_valid", mem_valid, 1);
    chk("resume_tid", mem_tid, 2'b00);

    // Reset pulsed mid-transfer; first tie afterwards goes to icache.
    idle();
    do_reset();
    ic_valid = 1; dc_valid = 1; ic_addr = 64'h7000; dc_addr = 64'h9000;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    #2;
    do_reset();
    mem_ready = 1;
    cycle();
    chk("post_rst_valid", mem_valid, 1);
    chk("post_rst_tid", mem_tid, 2'b00);

    // Random traffic against the model.
    idle();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      ic_valid = 1'($urandom_range(0, 1));
      ic_addr  = {$urandom, $urandom};
      ic_tid   = 1'($urandom_range(0, 1));
      dc_valid = 1'($urandom_range(0, 1));
      dc_addr  = {$urandom, $urandom};
      dc_we    = 1'($urandom_range(0, 1));
      dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      dc_be    = 16'($urandom);
      dc_tid   = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 19));
      rsp_data = {$urandom, $urandom, $urandom, $urandom};
      if (r < 8 && (m_cnt[0] + m_cnt[1]) > 0) begin
        rsp_valid = 1;
        if (m_cnt[0] == 0)      rsp_tid[1] = 1'b1;
        else if (m_cnt[1] == 0) rsp_tid[1] = 1'b0;
        else                    rsp_tid[1] = 1'($urandom_range(0, 1));
        rsp_tid[0] = 1'($urandom_range(0, 1));
      end else if (r == 19) begin
        rsp_valid = 1;
        rsp_tid   = 2'($urandom_range(0, 3));
      end else begin
        rsp_valid = 0;
      end
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
